// File: rtl/acc_input_framer.sv
// acc_input_framer
// Packs a serial stream of signed 8-bit samples into 4-lane vectors (X1 is the
// first sample of a vector). Complete vectors are queued in a DEPTH-entry
// FIFO whose head is presented to the accelerator. din_last closes a
// vector early, and the unused upper lanes are zero-filled.
//
// Ports
//   clk        in   rising-edge clock
//   arst       in   asynchronous active-high reset
//   din        in   signed sample
//   din_valid  in   producer has a sample on din
//   din_last   in   din is the final sample of a frame (forces vector close)
//   din_ready  out  framer accepts din this cycle (FIFO not full)
//   X1..X4     out  signed head vector
//   valid_out  out  head vector present (FIFO not empty)
//   ready_in   in   accelerator accepts the head vector
//   level      out  number of complete vectors stored, 0..DEPTH
module acc_input_framer #(
   parameter int DEPTH = 4,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                arst,
   input  logic signed [7:0]   din,
   input  logic                din_valid,
   input  logic                din_last,
   output logic                din_ready,
   output logic signed [7:0]   X1,
   output logic signed [7:0]   X2,
   output logic signed [7:0]   X3,
   output logic signed [7:0]   X4,
   output logic                valid_out,
   input  logic                ready_in,
   output logic [LW-1:0]       level
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {L0, L1, L2, L3} lane_e;

   lane_e              state_q;
   logic signed [7:0]  lane_q [4];
   logic [31:0]        mem_q [DEPTH];
   logic [PW-1:0]      wr_ptr_q;
   logic [PW-1:0]      rd_ptr_q;
   logic [LW-1:0]      level_q;
   logic [LW-1:0]      level_d;
   logic [31:0]        last_q;
   logic [31:0]        vec_d;
   logic [31:0]        head;
   logic               accept;
   logic               push;
   logic               pop;

   // Ready/valid come from the registered level only, so there is no
   // combinational path from ready_in to din_ready.
   assign din_ready = (level_q != LW'(DEPTH));
   assign valid_out = (level_q != '0);
   assign accept    = din_valid && din_ready;
   assign push      = accept && (din_last || (state_q == L3));
   assign pop       = valid_out && ready_in;
   assign level_d   = level_q + LW'(push) - LW'(pop);
   assign level     = level_q;

   // Vector being closed: earlier lanes from the lane registers, the current
   // lane from din, later lanes forced to zero for a din_last close.
   always_comb begin
      vec_d = '0;
      for (int i = 0; i < 4; i++) begin
         if (i < int'(state_q)) begin
            vec_d[8*i +: 8] = lane_q[i];
         end else if (i == int'(state_q)) begin
            vec_d[8*i +: 8] = din;
         end else begin
            vec_d[8*i +: 8] = 8'h00;
         end
      end
   end

   // Assembly FSM: state is the lane index of the next sample.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= L0;
         for (int i = 0; i < 4; i++) lane_q[i] <= '0;
      end else if (accept) begin
         if (push) begin
            // Clear lanes so a later padded vector never picks up stale data.
            state_q <= L0;
            for (int i = 0; i < 4; i++) lane_q[i] <= '0;
         end else begin
            lane_q[state_q] <= din;
            case (state_q)
               L0:      state_q <= L1;
               L1:      state_q <= L2;
               default: state_q <= L3;
            endcase
         end
      end
   end

   // FIFO storage (data only, no reset needed).
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= vec_d;
   end

   // FIFO control. Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         last_q   <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
            last_q   <= mem_q[rd_ptr_q];
         end
         level_q <= level_d;
      end
   end

   // When empty the outputs hold the most recently popped vector.
   assign head = valid_out ? mem_q[rd_ptr_q] : last_q;
   assign X1   = head[7:0];
   assign X2   = head[15:8];
   assign X3   = head[23:16];
   assign X4   = head[31:24];

endmodule

// File: tb/tb_acc_input_framer.sv
module tb_acc_input_framer;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              arst;
   logic signed [7:0] din;
   logic              din_valid;
   logic              din_last;
   logic              din_ready;
   logic signed [7:0] X1, X2, X3, X4;
   logic              valid_out;
   logic              ready_in;
   logic [LW-1:0]     level;

   acc_input_framer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .arst(arst), .din(din), .din_valid(din_valid),
      .din_last(din_last), .din_ready(din_ready), .X1(X1), .X2(X2),
      .X3(X3), .X4(X4), .valid_out(valid_out), .ready_in(ready_in),
      .level(level)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit run   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, act, exp);
      end
   endtask

   // Behavioural model: a queue of packed vectors plus a partial-frame buffer.
   logic [31:0] mq[$];
   logic [7:0]  part [4];
   int          cnt;
   logic [31:0] mlast;
   bit          m_pop;
   bit          m_acc;

   always @(posedge clk or posedge arst) begin
      if (arst) begin
         mq.delete();
         cnt   = 0;
         for (int i = 0; i < 4; i++) part[i] = 8'h00;
         mlast = 32'h0;
      end else begin
         m_pop = (mq.size() > 0) && ready_in;
         m_acc = din_valid && (mq.size() < DEPTH);
         if (m_pop) mlast = mq.pop_front();
         if (m_acc) begin
            part[cnt] = din;
            if (din_last || cnt == 3) begin
               mq.push_back({part[3], part[2], part[1], part[0]});
               for (int i = 0; i < 4; i++) part[i] = 8'h00;
               cnt = 0;
            end else begin
               cnt++;
            end
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (run && !arst) begin
         chk("level", 32'(level), 32'(mq.size()));
         chk("valid_out", 32'(valid_out), 32'(mq.size() > 0));
         chk("din_ready", 32'(din_ready), 32'(mq.size() < DEPTH));
         chk("X", {X4, X3, X2, X1}, (mq.size() > 0) ? mq[0] : mlast);
      end
   end

   // Window monitor for the continuous-streaming phase.
   bit phase5 = 0;
   int vcnt   = 0;
   int maxl   = 0;
   always @(negedge clk) begin
      if (phase5) begin
         if (valid_out) vcnt++;
         if (int'(level) > maxl) maxl = int'(level);
      end
   end

   task automatic send(input logic [7:0] v, input logic last);
      din       = v;
      din_valid = 1'b1;
      din_last  = last;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pop1();
      ready_in = 1'b1;
      @(posedge clk);
      #1;
      ready_in = 1'b0;
   endtask

   initial begin
      arst = 1'b1; din = '0; din_valid = 1'b0; din_last = 1'b0; ready_in = 1'b0;
      #12;
      arst = 1'b0;
      run  = 1'b1;
      @(posedge clk); #1;

      // Reset state
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_ready", 32'(din_ready), 32'd1);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_X", {X4, X3, X2, X1}, 32'h0);

      // Basic packing 1,2,3,4
      send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
      chk("pack_valid", 32'(valid_out), 32'd1);
      chk("pack_X", {X4, X3, X2, X1}, 32'h04030201);
      chk("pack_level", 32'(level), 32'd1);

      // Padded frame and clean follow-up vector
      send(8'h80, 0); send(8'h7F, 0); send(8'hFF, 1);
      send(8'd5, 0); send(8'd6, 0); send(8'd7, 0); send(8'd8, 0);
      chk("pad_level", 32'(level), 32'd3);
      pop1();
      chk("pad_X", {X4, X3, X2, X1}, 32'h00FF7F80);
      pop1();
      chk("clean_X", {X4, X3, X2, X1}, 32'h08070605);
      pop1();
      chk("empty_valid", 32'(valid_out), 32'd0);
      chk("hold_X", {X4, X3, X2, X1}, 32'h08070605);

      // Fill to DEPTH, overflow attempts, then one pop
      for (int i = 0; i < 4 * DEPTH; i++) send(8'(10 + i), 0);
      chk("full_level", 32'(level), 32'(DEPTH));
      chk("full_ready", 32'(din_ready), 32'd0);
      send(8'd99, 0); send(8'd99, 0); send(8'd99, 0);
      chk("full_block", 32'(level), 32'(DEPTH));
      pop1();
      chk("afterpop_level", 32'(level), 32'(DEPTH - 1));
      chk("afterpop_ready", 32'(din_ready), 32'd1);
      chk("afterpop_X", {X4, X3, X2, X1}, 32'h11100F0E);

      // Close a vector on the same edge as a pop, across pointer wrap
      send(8'd30, 0); send(8'd31, 0); send(8'd32, 0);
      ready_in = 1'b1;
      send(8'd33, 0);
      ready_in = 1'b0;
      chk("simul_level", 32'(level), 32'(DEPTH - 1));
      chk("simul_X", {X4, X3, X2, X1}, 32'h15141312);
      pop1();
      chk("wrap_X1", {X4, X3, X2, X1}, 32'h19181716);
      pop1();
      chk("wrap_X2", {X4, X3, X2, X1}, 32'h21201F1E);
      pop1();
      chk("wrap_empty", 32'(level), 32'd0);

      // Continuous streaming with ready_in held high
      ready_in = 1'b1;
      phase5   = 1'b1;
      for (int i = 0; i < 12; i++) send(8'(60 + i), 0);
      idle(2);
      phase5   = 1'b0;
      ready_in = 1'b0;
      chk("stream_pops", 32'(vcnt), 32'd3);
      chk("stream_maxlevel", 32'(maxl), 32'd1);
      chk("stream_lastX", {X4, X3, X2, X1}, 32'h47464544);

      // Reset in the middle of a frame
      send(8'd50, 0); send(8'd51, 0);
      #2;
      arst = 1'b1;
      #1;
      chk("arst_valid", 32'(valid_out), 32'd0);
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_X", {X4, X3, X2, X1}, 32'h0);
      chk("arst_ready", 32'(din_ready), 32'd1);
      #3;
      arst = 1'b0;
      @(posedge clk); #1;
      send(8'd41, 0); send(8'd42, 0); send(8'd43, 0); send(8'd44, 0);
      chk("post_rst_X", {X4, X3, X2, X1}, 32'h2C2B2A29);
      chk("post_rst_level", 32'(level), 32'd1);

      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
